decode_queue: RTL
=================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered instruction entries; power of two, >= 2.
REQ-002 Parameter PC_W, default 32, width of the program-counter tag carried with each instruction.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 valid_i  input  1  fetch side offers an instruction.
REQ-006 ready_o  output  1  queue can accept an instruction this cycle.
REQ-007 instr_i  input  32  raw instruction word.
REQ-008 pc_i  input  PC_W  PC of instr_i.
REQ-009 flush_i  input  1  discard all buffered instructions.
REQ-010 valid_o  output  1  head entry decoded and presented.
REQ-011 ready_i  input  1  downstream consumes the head entry.
REQ-012 pc_o  output  PC_W  PC of the head entry.
REQ-013 opcode_o 7, funct3_o 3, funct7_o 7, rd_o 5, rs1_o 5, rs2_o 5  outputs  head-entry fields at bits [6:0], [14:12], [31:25], [11:7], [19:15], [24:20].
REQ-014 inst_type_o  output  riscv_pkg::instruction_type_e  instruction class of the head entry.
REQ-015 imm_type_o  output  riscv_pkg::imm_type_e  immediate format of the head entry.
REQ-016 illegal_o  output  1  head entry is an illegal encoding.
REQ-017 count_o  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 Storage is a circular FIFO of DEPTH {instr, pc} entries with write pointer, read pointer and occupancy counter; pointers wrap from DEPTH-1 to 0.
REQ-019 Push when valid_i && ready_o; pop when valid_o && ready_i.
REQ-020 ready_o = (count_o != DEPTH); it does not depend on ready_i, so there is no push-on-full even with a simultaneous pop.
REQ-021 valid_o = (count_o != 0); there is no input-to-output bypass, so minimum latency from accepted push to valid_o is exactly 1 cycle.
REQ-022 Simultaneous push and pop: count_o is unchanged and both pointers advance.
REQ-023 Decoded outputs are combinational from the head entry: R_TYPE 0110011; I_TYPE 0010011, 0000011, 1100111; S_TYPE 0100011; B_TYPE 1100011; U_TYPE 0110111, 0010111; J_TYPE 1101111; UNKNOWN_TYPE otherwise.
REQ-024 imm_type_o mapping: I->IMM_I, S->IMM_S, B->IMM_B, U->IMM_U, J->IMM_J, otherwise IMM_NONE.
REQ-025 When valid_o=0, all decoded outputs, pc_o and illegal_o are 0 (inst_type_o = UNKNOWN_TYPE, imm_type_o = IMM_NONE).
REQ-026 flush_i=1: next cycle count_o=0 and pointers=0; pushes and pops in the flush cycle are discarded; flush has priority over everything.
REQ-027 Head entry and its outputs hold stable while valid_o=1 && ready_i=0.

Reset
REQ-028 On rst_ni low, asynchronously: pointers=0, count_o=0, valid_o=0, ready_o=1, all decoded outputs at their REQ-025 values; storage contents are not reset.
REQ-029 Reset asserted mid-operation discards all entries; the first push after release behaves as from empty.

Configuration
REQ-030 Macro DECODE_QUEUE_ILLEGAL_CHECK_EN defined: illegal_o=valid_o && (instr[1:0]!=2'b11 || inst_type_o==UNKNOWN_TYPE || (inst_type_o==R_TYPE && funct7_o not in {0000000, 0100000})).
REQ-031 Macro undefined: illegal_o is tied to 0 and no check logic is built.

Verification
REQ-032 Push 0x00A00093 (addi), pc 0x100, ready_i=1 -> next cycle valid_o=1, inst_type_o=I_TYPE, imm_type_o=IMM_I, rd_o=1, pc_o=0x100; popped, so valid_o=0 the cycle after.
REQ-033 DEPTH=4, ready_i=0, five pushes offered -> four accepted, ready_o=0 at count_o=4; fifth held until a pop.
REQ-034 count_o=4, push offered with ready_i=1 -> pop only, count_o=3; then pushes and pops both every cycle for 10 cycles -> count_o stays constant, PCs in order across pointer wrap.
REQ-035 count_o=3, flush_i=1 with push and pop offered -> next cycle count_o=0, valid_o=0.
REQ-036 With macro, push 0x00000000 -> illegal_o=1; push 0x40000033 (funct7 0100000, R_TYPE) -> illegal_o=0; without macro -> illegal_o=0 for both.
REQ-037 rst_ni low for one cycle with count_o=2 -> count_o=0 and valid_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types: instruction class and immediate format.
// The all-zero encodings are the idle values driven when no entry is presented.
package riscv_pkg;

  typedef enum logic [2:0] {
    UNKNOWN_TYPE = 3'd0,
    R_TYPE       = 3'd1,
    I_TYPE       = 3'd2,
    S_TYPE       = 3'd3,
    B_TYPE       = 3'd4,
    U_TYPE       = 3'd5,
    J_TYPE       = 3'd6
  } instruction_type_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and decode-side handshake bundle of the decode queue.
// slave = the queue itself, master = the fetch unit / downstream consumer pair.
interface decode_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
);
  import riscv_pkg::*;

  // fetch side
  logic                      valid_i;
  logic                      ready_o;
  logic [31:0]               instr_i;
  logic [PC_W-1:0]           pc_i;
  logic                      flush_i;

  // decode side
  logic                      valid_o;
  logic                      ready_i;
  logic [PC_W-1:0]           pc_o;
  logic [6:0]                opcode_o;
  logic [2:0]                funct3_o;
  logic [6:0]                funct7_o;
  logic [4:0]                rd_o;
  logic [4:0]                rs1_o;
  logic [4:0]                rs2_o;
  instruction_type_e         inst_type_o;
  imm_type_e                 imm_type_o;
  logic                      illegal_o;
  logic [$clog2(DEPTH):0]    count_o;

  modport slave (
    input  valid_i, instr_i, pc_i, flush_i, ready_i,
    output ready_o, valid_o, pc_o, opcode_o, funct3_o, funct7_o,
           rd_o, rs1_o, rs2_o, inst_type_o, imm_type_o, illegal_o, count_o
  );

  modport master (
    output valid_i, instr_i, pc_i, flush_i, ready_i,
    input  ready_o, valid_o, pc_o, opcode_o, funct3_o, funct7_o,
           rd_o, rs1_o, rs2_o, inst_type_o, imm_type_o, illegal_o, count_o
  );

endinterface

// File: rtl/decode_queue.sv
// Circular instruction FIFO with combinational decode of the head entry.
// Optional macro DECODE_QUEUE_ILLEGAL_CHECK_EN builds the illegal-encoding check.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  decode_queue_if.slave dq
);
  import riscv_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  function automatic instruction_type_e classify(input logic [6:0] op);
    instruction_type_e t;
    case (op)
      7'b0110011:                         t = R_TYPE;
      7'b0010011, 7'b0000011, 7'b1100111: t = I_TYPE;
      7'b0100011:                         t = S_TYPE;
      7'b1100011:                         t = B_TYPE;
      7'b0110111, 7'b0010111:             t = U_TYPE;
      7'b1101111:                         t = J_TYPE;
      default:                            t = UNKNOWN_TYPE;
    endcase
    return t;
  endfunction

  function automatic imm_type_e imm_of(input instruction_type_e t);
    imm_type_e m;
    case (t)
      I_TYPE:  m = IMM_I;
      S_TYPE:  m = IMM_S;
      B_TYPE:  m = IMM_B;
      U_TYPE:  m = IMM_U;
      J_TYPE:  m = IMM_J;
      default: m = IMM_NONE;
    endcase
    return m;
  endfunction

  logic [31:0]     instr_mem [DEPTH];
  logic [PC_W-1:0] pc_mem    [DEPTH];

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [31:0]     head_instr;
  logic [PC_W-1:0] head_pc;

  assign full  = (count == FULL);
  assign empty = (count == '0);

  // Acceptance looks only at occupancy, never at ready_i: a full queue refuses
  // pushes even when the head is being consumed in the same cycle.
  assign push  = dq.valid_i && !full;
  assign pop   = !empty && dq.ready_i;

  assign dq.ready_o = !full;
  assign dq.valid_o = !empty;
  assign dq.count_o = count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (dq.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; stale contents are masked by valid_o after reset.
  always_ff @(posedge clk_i) begin
    if (push && !dq.flush_i) begin
      instr_mem[wr_ptr] <= dq.instr_i;
      pc_mem[wr_ptr]    <= dq.pc_i;
    end
  end

  assign head_instr = instr_mem[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];

  always_comb begin
    dq.pc_o        = '0;
    dq.opcode_o    = '0;
    dq.funct3_o    = '0;
    dq.funct7_o    = '0;
    dq.rd_o        = '0;
    dq.rs1_o       = '0;
    dq.rs2_o       = '0;
    dq.inst_type_o = UNKNOWN_TYPE;
    dq.imm_type_o  = IMM_NONE;
    if (!empty) begin
      dq.pc_o        = head_pc;
      dq.opcode_o    = head_instr[6:0];
      dq.funct3_o    = head_instr[14:12];
      dq.funct7_o    = head_instr[31:25];
      dq.rd_o        = head_instr[11:7];
      dq.rs1_o       = head_instr[19:15];
      dq.rs2_o       = head_instr[24:20];
      dq.inst_type_o = classify(head_instr[6:0]);
      dq.imm_type_o  = imm_of(classify(head_instr[6:0]));
    end
  end

`ifdef DECODE_QUEUE_ILLEGAL_CHECK_EN
  // Compressed encodings, unknown opcodes and R-type funct7 outside the base set are illegal.
  assign dq.illegal_o = dq.valid_o &&
                        ((head_instr[1:0] != 2'b11) ||
                         (dq.inst_type_o == UNKNOWN_TYPE) ||
                         ((dq.inst_type_o == R_TYPE) &&
                          !((dq.funct7_o == 7'b0000000) || (dq.funct7_o == 7'b0100000))));
`else
  assign dq.illegal_o = 1'b0;
`endif

endmodule
